// File: rtl/series_tx.sv
// Serial transmitter: shifts DATA_W-bit words out LSB-first, then pads with GAP_CYCLES zero cycles.
// A shadow matcher counts the overlapping PATTERN occurrences in each emitted frame.
module series_tx #(
  parameter int                 DATA_W     = 32,
  parameter int                 PAT_W      = 4,
  parameter logic [PAT_W-1:0]   PATTERN    = 4'b1011,
  parameter int                 GAP_CYCLES = 2,
  parameter int                 COUNT_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               series,
  output logic               series_valid,
  output logic               match_pulse,
  output logic [COUNT_W-1:0] match_count,
  output logic               done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] MIN_PRIOR = BW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  shreg;
  logic [BW-1:0]      bit_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [PAT_W-2:0]   history;
  logic [PAT_W-1:0]   hist_win;
  logic               accept;
  logic               last_bit;
  logic               gap_end;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign gap_end  = (state == GAP) && (gap_cnt == '0);
  assign hist_win = {history, series};

  // bit_cnt is the index of the bit on series, i.e. the number of prior frame bits
  assign match_pulse = series_valid && (state == SHIFT) && (bit_cnt >= MIN_PRIOR) &&
                       (hist_win == PATTERN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      history      <= '0;
      series       <= 1'b0;
      series_valid <= 1'b0;
      match_count  <= '0;
      done         <= 1'b0;
    end else begin
      done <= last_bit;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg        <= in_data >> 1;
            series       <= in_data[0];
            series_valid <= 1'b1;
            bit_cnt      <= '0;
            history      <= '0;
            match_count  <= '0;
          end else begin
            series       <= 1'b0;
            series_valid <= 1'b0;
          end
        end
        SHIFT: begin
          history <= hist_win[PAT_W-2:0];
          if (match_pulse && (match_count != '1))
            match_count <= match_count + 1'b1;
          if (last_bit) begin
            series       <= 1'b0;
            series_valid <= 1'b0;
            gap_cnt      <= GAP_LOAD;
          end else begin
            series  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        GAP: begin
          series       <= 1'b0;
          series_valid <= 1'b0;
          if (!gap_end) gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          series       <= 1'b0;
          series_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_series_tx.sv
// Directed and random checks of series_tx: bit order, match pulses/counts, gap timing, reset.
// A second instance with a 2-bit counter exercises match_count saturation.
module tb_series_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, series, series_valid, match_pulse, done;
  logic [5:0]  match_count;
  logic        s_ready, s_series, s_valid, s_pulse, s_done;
  logic [1:0]  s_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  series_tx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .series(series), .series_valid(series_valid), .match_pulse(match_pulse),
    .match_count(match_count), .done(done)
  );

  series_tx #(.COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ready), .in_data(in_data),
    .series(s_series), .series_valid(s_valid), .match_pulse(s_pulse),
    .match_count(s_count), .done(s_done)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    int          cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic model(input logic [31:0] d, output logic [31:0] m, output int c);
    logic [3:0] h = '0;
    m = '0;
    c = 0;
    for (int k = 0; k < 32; k++) begin
      h = {h[2:0], d[k]};
      if (k >= 3 && h == 4'b1011) begin
        m[k] = 1'b1;
        c++;
      end
    end
  endtask

  task automatic run_frame(input logic [31:0] d, input logic [31:0] m, input int c);
    int sat;
    sat = (c > 3) ? 3 : c;
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("series[%0d]", k), 32'(series), 32'(d[k]));
      check($sformatf("series_valid[%0d]", k), 32'(series_valid), 32'd1);
      check($sformatf("match_pulse[%0d]", k), 32'(match_pulse), 32'(m[k]));
      if (in_ready) check($sformatf("ready_busy[%0d]", k), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("gap_valid", 32'(series_valid), 32'd0);
    check("match_count", 32'(match_count), 32'(c));
    check("sat_count", 32'(s_count), 32'(sat));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("gap_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("count_hold", 32'(match_count), 32'(c));
  endtask

  initial begin
    logic [31:0] m, d;
    int c, n, seen;

    vecs[0] = '{32'h0000000D, 32'h00000008, 1};
    vecs[1] = '{32'h0000006D, 32'h00000048, 2};
    vecs[2] = '{32'h00000000, 32'h00000000, 0};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 0};
    vecs[4] = '{32'hDDDDDDDD, 32'h88888888, 8};

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_series", 32'(series), 32'd0);
    check("rst_valid", 32'(series_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) run_frame(vecs[i].data, vecs[i].mask, vecs[i].cnt);

    // back-to-back: source holds in_valid, second word waits for the gap to finish
    wait_ready();
    in_valid = 1'b1;
    in_data  = 32'hA0000000;
    @(posedge clk);
    #1 in_data = 32'h00000001;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'd34);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_first_bit", 32'(series), 32'd1);
    check("b2b_first_valid", 32'(series_valid), 32'd1);
    check("b2b_count_clear", 32'(match_count), 32'd0);
    repeat (32) @(negedge clk);
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_count", 32'(match_count), 32'd0);

    // reset in the middle of a frame
    wait_ready();
    in_valid = 1'b1;
    in_data  = 32'h0000000D;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_count", 32'(match_count), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_series", 32'(series), 32'd0);
    check("midrst_valid", 32'(series_valid), 32'd0);
    check("midrst_count", 32'(match_count), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1 check("midrst_ready_after", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      if (i % 3 == 0) d = d | 32'h00B6D000;
      model(d, m, c);
      run_frame(d, m, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
